matrix_memory_responder: RTL
============================

# matrix_memory_responder

Memory-side responder for the execution unit's address-bus protocol. Decodes transactions whose target field selects memory and whose execution-phase code is source-1 read, source-2 read or destination write. Serves 256-bit matrix operands (4x4 of 16-bit) from a 16-entry array, or stores ALU results into it. Sits between the execution unit (initiator) and the ALU (operand consumer, result producer).

## Interface
- DEPTH, 16, number of 256-bit matrix entries; index is addressBus[7:4]
- DATA_W, 256, entry width
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-low
- addressBus  in  16  [15:12] target (4'h1 = memory), [11:8] instruction index (ignored), [7:4] entry index, [3:0] register field (ignored)
- executionData  in  4  phase code: 4'h2 source 1, 4'h3 source 2, 4'h5 destination
- cmdValid  in  1  initiator strobe; bus and phase valid this cycle
- cmdReady  out  1  responder can accept a command
- readData  out  DATA_W  operand to ALU
- readValid  out  1  readData valid; held until readAck
- readAck  in  1  ALU consumed readData
- sourceSel  out  1  0 = readData is source 1, 1 = source 2
- writeData  in  DATA_W  result from ALU
- writeValid  in  1  writeData valid
- done  out  1  one-cycle pulse after a destination write commits
- errFlag  out  1  sticky: memory-targeted command with unsupported phase code
- loadEn  in  1  preload strobe (bench/boot)
- loadAddr  in  4  preload index
- loadData  in  DATA_W  preload data

## Operation
- States: IDLE, READ, RESP, WRITE, DONE.
- IDLE: cmdReady = !loadEn. Accept = cmdValid & cmdReady & addressBus[15:12]==4'h1. Non-memory targets are ignored; state stays IDLE, no outputs change.
- On accept, capture index = addressBus[7:4], phase = executionData.
  - phase 2 or 3 -> READ; sourceSel <= (phase==3).
  - phase 5 -> WRITE.
  - any other -> errFlag <= 1, stay IDLE.
- READ: readData <= mem[index]; -> RESP.
- RESP: readValid = 1, readData and sourceSel stable. When readAck is sampled high -> IDLE, readValid drops next cycle.
- WRITE: wait for writeValid. On the edge where it is sampled high, mem[index] <= writeData; -> DONE.
- DONE: done = 1 for exactly one cycle; -> IDLE.
- Preload: loadEn in IDLE writes mem[loadAddr] <= loadData that edge, and blocks cmd acceptance. loadEn outside IDLE is ignored.
- cmdReady = 0 in every state except IDLE.
- readAck outside RESP and writeValid outside WRITE are ignored.
- errFlag clears only on reset.
- Reset (async, any state): state IDLE; readData = 0, readValid = 0, sourceSel = 0, done = 0, errFlag = 0; cmdReady = 1 after deassertion. Memory contents are not reset and are preserved across a mid-operation reset. An in-flight write with writeValid not yet sampled is dropped.

## Timing
- Read: accept at edge N; READ during N..N+1; readValid high from edge N+2. Minimum turnaround: readAck at N+2 -> IDLE at N+3, next accept at N+3.
- Write: accept at N; WRITE from N+1; commit at the first edge with writeValid = 1, say M; done high M..M+1; cmdReady high from M+2.
- Read-after-write to the same index returns the new data. Write and read commit in separate states, so no bypass is needed.
- Preload then command in the next cycle sees the preloaded data.

## Test plan
- Preload mem[2] = 256'h…0001 pattern, mem[5] = all-F. Send phase 2 / index 2, then phase 3 / index 5 with readAck on the first readValid cycle. Required: readValid asserted 2 cycles after each accept, readData matches each entry, sourceSel = 0 then 1.
- Phase 5 / index 6, writeValid delayed 3 cycles with writeData = 256'hA5…A5. Required: cmdReady low throughout, done pulses once on the cycle after commit. A following phase 2 read of index 6 returns A5…A5.
- cmdValid with target 4'h0 (instruction) and 4'h2 (ALU). Required: no state change, no readValid or done, cmdReady stays 1.
- Memory-targeted phase 4'h4. Required: errFlag = 1, remains set through subsequent valid reads, clears only on reset.
- readAck withheld 10 cycles. Required: readValid and readData stable the whole time, cmdReady low, no new command accepted.
- Reset asserted in RESP and again in WRITE. Required: all outputs zero immediately, cmdReady = 1 after release, previously preloaded entries read back unchanged, interrupted write not committed.

Source files
------------

// File: rtl/matrix_memory_responder.sv
// matrix_memory_responder
// Memory-side responder on the execution unit's address bus. It serves 4x4x16-bit
// matrix operands from a 16-entry array to the ALU, and stores ALU results back.
// Ports:
//   clock, reset (async, active-low)
//   addressBus/executionData/cmdValid/cmdReady : command from the execution unit
//   readData/readValid/readAck/sourceSel        : operand handshake to the ALU
//   writeData/writeValid/done                   : result handshake from the ALU
//   errFlag                                     : sticky unsupported-phase error
//   loadEn/loadAddr/loadData                    : preload port, honoured only when idle
module matrix_memory_responder #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 256
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [15:0]       addressBus,
   input  logic [3:0]        executionData,
   input  logic              cmdValid,
   output logic              cmdReady,
   output logic [DATA_W-1:0] readData,
   output logic              readValid,
   input  logic              readAck,
   output logic              sourceSel,
   input  logic [DATA_W-1:0] writeData,
   input  logic              writeValid,
   output logic              done,
   output logic              errFlag,
   input  logic              loadEn,
   input  logic [3:0]        loadAddr,
   input  logic [DATA_W-1:0] loadData
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_RESP  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [3:0] TGT_MEM   = 4'h1;
   localparam logic [3:0] PH_SRC1   = 4'h2;
   localparam logic [3:0] PH_SRC2   = 4'h3;
   localparam logic [3:0] PH_DEST   = 4'h5;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic              src_sel_q, src_sel_d;
   logic [DATA_W-1:0] read_data_q, read_data_d;
   logic              read_valid_q, read_valid_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              mem_we;
   logic [3:0]        mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // Instruction index and register field are carried on the bus but not used here.
   logic unused_bus_bits;
   assign unused_bus_bits = ^{addressBus[11:8], addressBus[3:0]};

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      src_sel_d    = src_sel_q;
      read_data_d  = read_data_q;
      read_valid_d = read_valid_q;
      done_d       = 1'b0;
      err_d        = err_q;
      mem_we       = 1'b0;
      mem_waddr    = loadAddr;
      mem_wdata    = loadData;

      unique case (state_q)
         S_IDLE: begin
            // Preload takes priority and holds off command acceptance.
            if (loadEn && reset) begin
               mem_we = 1'b1;
            end else if (cmdValid && addressBus[15:12] == TGT_MEM) begin
               idx_d = addressBus[7:4];
               if (executionData == PH_SRC1 || executionData == PH_SRC2) begin
                  state_d   = S_READ;
                  src_sel_d = (executionData == PH_SRC2);
               end else if (executionData == PH_DEST) begin
                  state_d = S_WRITE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_READ: begin
            read_data_d = mem[idx_q];
            state_d     = S_RESP;
         end
         S_RESP: begin
            // readValid is registered one cycle into RESP; the ack only counts
            // once the ALU has actually been shown a valid operand.
            read_valid_d = 1'b1;
            if (read_valid_q && readAck) begin
               read_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         S_WRITE: begin
            if (writeValid) begin
               mem_we    = 1'b1;
               mem_waddr = idx_q;
               mem_wdata = writeData;
               done_d    = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         idx_q        <= 4'd0;
         src_sel_q    <= 1'b0;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         src_sel_q    <= src_sel_d;
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   // Storage is deliberately outside the reset domain so contents survive a reset.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign cmdReady  = reset && (state_q == S_IDLE) && !loadEn;
   assign readData  = read_data_q;
   assign readValid = read_valid_q;
   assign sourceSel = src_sel_q;
   assign done      = done_q;
   assign errFlag   = err_q;

endmodule
